// File: rtl/locker_pkg.sv
// Shared definitions for the locker keypad: key codes, arbiter states and
// small helpers used by btn_conditioner and by the combination FSM.
package locker_pkg;

  localparam int NUM_KEYS = 6;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_NONE = 4'd0;
  localparam key_code_t KEY_A    = 4'd1;
  localparam key_code_t KEY_B    = 4'd2;
  localparam key_code_t KEY_C    = 4'd3;
  localparam key_code_t KEY_D    = 4'd4;
  localparam key_code_t KEY_E    = 4'd5;
  localparam key_code_t KEY_F    = 4'd6;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_HELD = 1'b1
  } arb_state_e;

  // Highest-priority set bit wins; bit 0 is key A (highest), bit 5 is key F.
  function automatic key_code_t key_encode(input logic [NUM_KEYS-1:0] v);
    key_code_t code;
    code = KEY_NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) code = key_code_t'(i + 1);
    end
    return code;
  endfunction

  // One-hot button vector for a key code; all zero for KEY_NONE.
  function automatic logic [NUM_KEYS-1:0] key_onehot(input key_code_t code);
    logic [NUM_KEYS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (code == key_code_t'(i + 1)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser followed by a counter-based debouncer.
// DEB changes only after the synchronised input has differed from it for
// DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic RAW,
  output logic DEB
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronise the raw level, then count stable disagreement before toggling DEB.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      DEB   <= 1'b0;
    end else begin
      sync1 <= RAW;
      sync2 <= sync1;
      if (sync2 != DEB) begin
        if (cnt == CNT_LAST) begin
          DEB <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Keypad front end: six debounced buttons, rising-edge detect, fixed
// priority A > B > C > D > E > F, and an optional held-key lockout.
// Configuration macro: BTN_LOCKOUT_EN. When defined, after one pulse no
// further pulse is issued until every button has been debounced-released.
// KEY_VALID qualifies KEY_CODE and BTNA..BTNF for exactly one cycle; there is
// no ready/backpressure, the consumer must take the pulse in that cycle.
// ARB_STATE exposes the arbiter state for observation.
module btn_conditioner
  import locker_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTNA_RAW,
  input  logic       BTNB_RAW,
  input  logic       BTNC_RAW,
  input  logic       BTND_RAW,
  input  logic       BTNE_RAW,
  input  logic       BTNF_RAW,
  output logic       BTNA,
  output logic       BTNB,
  output logic       BTNC,
  output logic       BTND,
  output logic       BTNE,
  output logic       BTNF,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       ANY_HELD,
  output arb_state_e ARB_STATE
);

  logic [NUM_KEYS-1:0] raw;
  logic [NUM_KEYS-1:0] deb;
  logic [NUM_KEYS-1:0] deb_q;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] btn_q;
  key_code_t           win_code;
  key_code_t           key_code_q;
  logic                key_valid_q;
  logic                any_held_q;
  arb_state_e          state;

  assign raw = {BTNF_RAW, BTNE_RAW, BTND_RAW, BTNC_RAW, BTNB_RAW, BTNA_RAW};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .CLK(CLK),
      .RST(RST),
      .RAW(raw[i]),
      .DEB(deb[i])
    );
  end

  // deb is the freshly debounced level, deb_q its previous value.
  assign rise     = deb & ~deb_q;
  assign win_code = key_encode(rise);

  // Arbiter: pulse the winning rising edge; with lockout, wait for full release.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ARB_IDLE;
      deb_q       <= '0;
      btn_q       <= '0;
      key_code_q  <= KEY_NONE;
      key_valid_q <= 1'b0;
      any_held_q  <= 1'b0;
    end else begin
      deb_q       <= deb;
      any_held_q  <= |deb;
      btn_q       <= '0;
      key_code_q  <= KEY_NONE;
      key_valid_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (win_code != KEY_NONE) begin
            btn_q       <= key_onehot(win_code);
            key_code_q  <= win_code;
            key_valid_q <= 1'b1;
`ifdef BTN_LOCKOUT_EN
            state       <= ARB_HELD;
`else
            state       <= ARB_IDLE;
`endif
          end
        end
        ARB_HELD: begin
          if (deb == '0) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign BTNA      = btn_q[0];
  assign BTNB      = btn_q[1];
  assign BTNC      = btn_q[2];
  assign BTND      = btn_q[3];
  assign BTNE      = btn_q[4];
  assign BTNF      = btn_q[5];
  assign KEY_CODE  = key_code_q;
  assign KEY_VALID = key_valid_q;
  assign ANY_HELD  = any_held_q;
  assign ARB_STATE = state;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs change on the falling edge; the next rising edge is "edge 0" of a
// scenario and outputs are sampled on the falling edge after each edge k.
module tb_btn_conditioner;
  import locker_pkg::*;

  localparam int DC = 4;
`ifdef BTN_LOCKOUT_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] raw;
  logic       btna, btnb, btnc, btnd, btne, btnf;
  logic [3:0] key_code;
  logic       key_valid;
  logic       any_held;
  arb_state_e arb_state;
  logic [10:0] obs;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  btn_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .CLK      (clk),
    .RST      (rst),
    .BTNA_RAW (raw[0]),
    .BTNB_RAW (raw[1]),
    .BTNC_RAW (raw[2]),
    .BTND_RAW (raw[3]),
    .BTNE_RAW (raw[4]),
    .BTNF_RAW (raw[5]),
    .BTNA     (btna),
    .BTNB     (btnb),
    .BTNC     (btnc),
    .BTND     (btnd),
    .BTNE     (btne),
    .BTNF     (btnf),
    .KEY_CODE (key_code),
    .KEY_VALID(key_valid),
    .ANY_HELD (any_held),
    .ARB_STATE(arb_state)
  );

  assign obs = {btnf, btne, btnd, btnc, btnb, btna, key_valid, key_code};

  // Expected {BTNF..BTNA, KEY_VALID, KEY_CODE} for a key code (0 = no pulse).
  function automatic logic [10:0] exp_word(input int code);
    logic [5:0] oh;
    oh = '0;
    if (code > 0) oh[code-1] = 1'b1;
    return {oh, (code > 0), 4'(code)};
  endfunction

  // Driver
  task automatic set_raw(input logic [5:0] v);
    raw = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_raw(6'b0);
    repeat (3) @(negedge clk);
    n_checks++; if (obs !== 11'd0) $display("FAIL reset_outputs got=%h exp=%h", obs, 11'd0); else n_pass++;
    n_checks++; if (any_held !== 1'b0) $display("FAIL reset_any_held got=%b exp=0", any_held); else n_pass++;
    n_checks++; if (arb_state !== ARB_IDLE) $display("FAIL reset_state got=%0d exp=%0d", arb_state, ARB_IDLE); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean_press();
    set_raw(6'b000100);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++; if (obs !== exp_word(k == 6 ? 3 : 0)) $display("FAIL clean_press k=%0d got=%h exp=%h", k, obs, exp_word(k == 6 ? 3 : 0)); else n_pass++;
      if (k == 5 || k == 6) begin
        n_checks++; if (any_held !== (k == 6)) $display("FAIL press_any_held k=%0d got=%b exp=%b", k, any_held, (k == 6)); else n_pass++;
      end
    end
    set_raw(6'b0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++; if (obs !== 11'd0) $display("FAIL clean_release k=%0d got=%h exp=%h", k, obs, 11'd0); else n_pass++;
      if (k == 5 || k == 6) begin
        n_checks++; if (any_held !== (k == 5)) $display("FAIL release_any_held k=%0d got=%b exp=%b", k, any_held, (k == 5)); else n_pass++;
      end
    end
  endtask

  task automatic test_bounce();
    logic [15:0] pat;
    pat = 16'b1111_1111_1101_1011;
    for (int k = 0; k < 16; k++) begin
      set_raw({5'b0, pat[k]});
      @(negedge clk);
      n_checks++; if (obs !== exp_word(k == 12 ? 1 : 0)) $display("FAIL bounce k=%0d got=%h exp=%h", k, obs, exp_word(k == 12 ? 1 : 0)); else n_pass++;
    end
    set_raw(6'b0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++; if (obs !== 11'd0) $display("FAIL bounce_release k=%0d got=%h exp=%h", k, obs, 11'd0); else n_pass++;
    end
  endtask

  task automatic test_priority();
    set_raw(6'b010010);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++; if (obs !== exp_word(k == 6 ? 2 : 0)) $display("FAIL priority k=%0d got=%h exp=%h", k, obs, exp_word(k == 6 ? 2 : 0)); else n_pass++;
    end
    set_raw(6'b0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++; if (obs !== 11'd0) $display("FAIL priority_release k=%0d got=%h exp=%h", k, obs, 11'd0); else n_pass++;
    end
  endtask

  task automatic test_lockout();
    int e;
    for (int k = 0; k < 20; k++) begin
      if (k == 0)  set_raw(6'b000001);
      if (k == 10) set_raw(6'b100001);
      @(negedge clk);
      e = (k == 6) ? 1 : ((k == 16 && !LOCK) ? 6 : 0);
      n_checks++; if (obs !== exp_word(e)) $display("FAIL roll k=%0d got=%h exp=%h", k, obs, exp_word(e)); else n_pass++;
      if (k == 10) begin
        n_checks++; if (arb_state !== (LOCK ? ARB_HELD : ARB_IDLE)) $display("FAIL roll_state got=%0d exp=%0d", arb_state, (LOCK ? ARB_HELD : ARB_IDLE)); else n_pass++;
      end
    end
    set_raw(6'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++; if (obs !== 11'd0) $display("FAIL roll_release k=%0d got=%h exp=%h", k, obs, 11'd0); else n_pass++;
    end
    n_checks++; if (arb_state !== ARB_IDLE) $display("FAIL release_state got=%0d exp=%0d", arb_state, ARB_IDLE); else n_pass++;
    set_raw(6'b100000);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++; if (obs !== exp_word(k == 6 ? 6 : 0)) $display("FAIL repress_f k=%0d got=%h exp=%h", k, obs, exp_word(k == 6 ? 6 : 0)); else n_pass++;
    end
    set_raw(6'b0);
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_held();
    rst = 1'b1;
    set_raw(6'b001000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if ({obs, any_held} !== 12'd0) $display("FAIL in_reset k=%0d got=%h exp=%h", k, {obs, any_held}, 12'd0); else n_pass++;
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++; if (obs !== exp_word(k == 6 ? 4 : 0)) $display("FAIL held_reset k=%0d got=%h exp=%h", k, obs, exp_word(k == 6 ? 4 : 0)); else n_pass++;
    end
    set_raw(6'b0);
    repeat (12) @(negedge clk);
    // Reset lands on the edge that would have produced the E pulse.
    set_raw(6'b010000);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++; if (obs !== 11'd0) $display("FAIL pre_drop k=%0d got=%h exp=%h", k, obs, 11'd0); else n_pass++;
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({obs, any_held} !== 12'd0) $display("FAIL pulse_dropped got=%h exp=%h", {obs, any_held}, 12'd0); else n_pass++;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++; if (obs !== exp_word(k == 6 ? 5 : 0)) $display("FAIL after_drop k=%0d got=%h exp=%h", k, obs, exp_word(k == 6 ? 5 : 0)); else n_pass++;
    end
    set_raw(6'b0);
    repeat (12) @(negedge clk);
  endtask

  task automatic test_sequence();
    int i;
    int p;
    int e;
    logic [3:0] want;
    exp_q.delete();
    for (int c = 1; c <= 6; c++) exp_q.push_back(4'(c));
    for (int k = 0; k < 6 * 16 + 16; k++) begin
      i = k / 16;
      p = k % 16;
      set_raw((i < 6 && p < 8) ? 6'(1 << i) : 6'b0);
      @(negedge clk);
      e = (i < 6 && p == 6) ? i + 1 : 0;
      n_checks++; if (obs !== exp_word(e)) $display("FAIL sequence k=%0d got=%h exp=%h", k, obs, exp_word(e)); else n_pass++;
      if (key_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL seq_extra k=%0d got=%0d exp=none", k, key_code);
        end else begin
          want = exp_q.pop_front();
          if (key_code !== want) $display("FAIL seq_code k=%0d got=%0d exp=%0d", k, key_code, want); else n_pass++;
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL seq_missing left=%0d exp=0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    raw = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_priority();
    test_lockout();
    test_reset_held();
    test_sequence();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
